// File: rtl/wb_sram_bridge_if.sv
// Bus bundle between a block fetch/store master and the SRAM bridge.
// Signal names are taken from the slave's point of view (_i into the bridge).
interface wb_sram_bridge_if #(
  parameter int ABITS = 9,
  parameter int WIDTH = 32
);
  localparam int BYTES = WIDTH / 8;

  logic             cyc_i;
  logic             stb_i;
  logic             we_i;
  logic [ABITS-1:0] adr_i;
  logic [BYTES-1:0] sel_i;
  logic [WIDTH-1:0] dat_i;
  logic             ack_o;
  logic             wat_o;
  logic             rty_o;
  logic             err_o;
  logic [WIDTH-1:0] dat_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output ack_o, wat_o, rty_o, err_o, dat_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  ack_o, wat_o, rty_o, err_o, dat_o
  );
endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone-like slave that drives one port of a synchronous block SRAM.
// Requests are forwarded combinationally so the SRAM samples them on the
// accepting edge; a TICKS-deep shift register times the acknowledge so it
// lines up with the SRAM's registered read data.
module wb_sram_bridge #(
  parameter int ABITS = 9,
  parameter int WIDTH = 32,
  parameter int USEBE = 1,
  parameter int PIPED = 1,
  parameter int TICKS = 1,
  parameter int DELAY = 3,
  localparam int BYTES = WIDTH / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_sram_bridge_if.slave  bus,
  output logic             sram_ce_o,
  output logic             sram_we_o,
  output logic [ABITS-1:0] sram_adr_o,
  output logic [BYTES-1:0] sram_bes_o,
  input  logic [WIDTH-1:0] sram_dat_i,
  output logic [WIDTH-1:0] sram_dat_o
);

  // Reject parameter sets the hardware cannot honour. DELAY only describes
  // clock-to-output timing for behavioural models, so only its sign matters.
  if (TICKS < 1 || TICKS > 3 || (WIDTH % 8) != 0 || DELAY < 0) begin : g_param_check
    $error("wb_sram_bridge: illegal parameter set");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TICKS-1:0] r_ack_sr;

  logic             w_busy;
  logic             w_wat;
  logic             w_acc;
  logic             w_ack;
  logic             w_wr;
  logic [BYTES-1:0] w_lane_mask;

  // Classic mode stalls a new strobe while one request is in flight;
  // pipelined mode never stalls.
  assign w_busy = (r_state == ST_BUSY);
  assign w_wat  = (PIPED != 0) ? 1'b0 : (w_busy & bus.cyc_i & bus.stb_i);

  // Reset suppresses acceptance so the SRAM is never enabled during reset.
  assign w_acc  = bus.cyc_i & bus.stb_i & ~w_wat & ~rst_i;
  assign w_wr   = w_acc & bus.we_i;

  // Dropping cyc_i abandons the cycle: any ack still in flight is hidden.
  assign w_ack  = r_ack_sr[TICKS-1] & bus.cyc_i;

  assign w_lane_mask = (USEBE != 0) ? bus.sel_i : {BYTES{1'b1}};

  // ---- stage 0: SRAM request, sampled by the SRAM on the accepting edge
  assign sram_ce_o  = w_acc;
  assign sram_we_o  = w_wr;
  assign sram_adr_o = bus.adr_i;
  assign sram_dat_o = bus.dat_i;
  assign sram_bes_o = {BYTES{w_wr}} & w_lane_mask;

  // ---- stages 1..TICKS: ack travels alongside the SRAM read pipeline
  // Ack delay line; cleared on reset or when the master drops the cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !bus.cyc_i) begin
      r_ack_sr <= '0;
    end else begin
      r_ack_sr[0] <= w_acc;
      for (int i = 1; i < TICKS; i++) begin
        r_ack_sr[i] <= r_ack_sr[i-1];
      end
    end
  end

  // Outstanding-request state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Busy tracking: enter on accept in classic mode, leave on the ack. Leaving
  // on a dropped cycle too avoids waiting forever for an ack that was flushed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && (PIPED == 0)) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_ack || !bus.cyc_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // SRAM latency already aligns read data with the ack, so data passes through.
  assign bus.dat_o = sram_dat_i;
  assign bus.ack_o = w_ack;
  assign bus.wat_o = w_wat;
  assign bus.rty_o = 1'b0;
  assign bus.err_o = 1'b0;

endmodule

// File: tb/tb_wb_sram_bridge.sv
`timescale 1ns/1ps
module tb_wb_sram_bridge;
  localparam int AB = 9;
  localparam int W  = 32;
  localparam int BY = W / 8;
  localparam int TA = 1;   // DUT A: pipelined, byte enables honoured
  localparam int TB = 2;   // DUT B: classic, byte enables ignored

  typedef struct {
    bit          rd;
    logic [W-1:0] data;
    int unsigned t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic rst_a, rst_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  logic [W-1:0] ref_a [16];
  logic [W-1:0] ref_b [16];

  wb_sram_bridge_if #(.ABITS(AB), .WIDTH(W)) bus_a ();
  wb_sram_bridge_if #(.ABITS(AB), .WIDTH(W)) bus_b ();

  logic          a_ce, a_we, b_ce, b_we;
  logic [AB-1:0] a_adr, b_adr;
  logic [BY-1:0] a_bes, b_bes;
  logic [W-1:0]  a_wd, b_wd, a_rd, b_rd0, b_rd1;
  logic [W-1:0]  mem_a [0:(1<<AB)-1];
  logic [W-1:0]  mem_b [0:(1<<AB)-1];

  wb_sram_bridge #(.ABITS(AB), .WIDTH(W), .USEBE(1), .PIPED(1), .TICKS(TA), .DELAY(3)) u_a (
    .clk_i(clk), .rst_i(rst_a), .bus(bus_a),
    .sram_ce_o(a_ce), .sram_we_o(a_we), .sram_adr_o(a_adr), .sram_bes_o(a_bes),
    .sram_dat_i(a_rd), .sram_dat_o(a_wd)
  );

  wb_sram_bridge #(.ABITS(AB), .WIDTH(W), .USEBE(0), .PIPED(0), .TICKS(TB), .DELAY(3)) u_b (
    .clk_i(clk), .rst_i(rst_b), .bus(bus_b),
    .sram_ce_o(b_ce), .sram_we_o(b_we), .sram_adr_o(b_adr), .sram_bes_o(b_bes),
    .sram_dat_i(b_rd1), .sram_dat_o(b_wd)
  );

  // Block SRAM models: 1-cycle read for A, 2-cycle read for B.
  always @(posedge clk) begin
    if (a_ce && a_we)
      for (int l = 0; l < BY; l++) if (a_bes[l]) mem_a[a_adr][l*8 +: 8] <= a_wd[l*8 +: 8];
    if (a_ce && !a_we) a_rd <= mem_a[a_adr];
  end

  always @(posedge clk) begin
    if (b_ce && b_we)
      for (int l = 0; l < BY; l++) if (b_bes[l]) mem_b[b_adr][l*8 +: 8] <= b_wd[l*8 +: 8];
    if (b_ce && !b_we) b_rd0 <= mem_b[b_adr];
    b_rd1 <= b_rd0;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference write rule: selected lanes replaced, or all lanes without byte enables.
  function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                         input logic [BY-1:0] sel, input bit usebe);
    logic [W-1:0] r;
    r = old_w;
    for (int l = 0; l < BY; l++) if (!usebe || sel[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  // Monitors: every ack must match the oldest pending request, TICKS cycles after issue.
  always @(negedge clk) begin
    if (mon_en) begin
      check("a_rty_err", {bus_a.rty_o, bus_a.err_o}, 2'b00);
      if (bus_a.ack_o === 1'b1) begin
        check("a_ack_expected", q_a.size() != 0, 1);
        if (q_a.size() != 0) begin
          ea = q_a.pop_front();
          check("a_ack_latency", cyc_cnt - ea.t, TA);
          if (ea.rd) check("a_rdata", bus_a.dat_o, ea.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("b_rty_err", {bus_b.rty_o, bus_b.err_o}, 2'b00);
      if (bus_b.ack_o === 1'b1) begin
        check("b_ack_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) begin
          eb = q_b.pop_front();
          check("b_ack_latency", cyc_cnt - eb.t, TB);
          if (eb.rd) check("b_rdata", bus_b.dat_o, eb.data);
        end
      end
    end
  end

  // One bus cycle on DUT A; entered and left at posedge+1.
  task automatic a_cycle(input bit cyc, input bit stb, input bit we, input int adr,
                         input logic [BY-1:0] sel, input logic [W-1:0] dat, input bit ack_zero);
    bit acc;
    bit in_rst;
    exp_t e;
    bus_a.cyc_i = cyc; bus_a.stb_i = stb; bus_a.we_i = we;
    bus_a.adr_i = AB'(adr); bus_a.sel_i = sel; bus_a.dat_i = dat;
    in_rst = rst_a;
    acc = cyc && stb && !in_rst;
    if (!cyc) q_a.delete();
    #2;
    check("a_wat", bus_a.wat_o, 0);
    check("a_ce", a_ce, acc);
    if (acc) begin
      check("a_we", a_we, we);
      check("a_adr", a_adr, adr);
      check("a_bes", a_bes, we ? sel : '0);
      if (we) check("a_wdat", a_wd, dat);
      e.rd = !we; e.t = cyc_cnt;
      if (we) begin
        ref_a[adr] = merge(ref_a[adr], dat, sel, 1'b1);
        e.data = '0;
      end else begin
        e.data = ref_a[adr];
      end
      q_a.push_back(e);
    end
    if (ack_zero) check("a_ack_zero", bus_a.ack_o, 0);
    @(posedge clk);
    if (in_rst) q_a.delete();
    #1;
  endtask

  // One classic transfer on DUT B: strobe held until the ack, then released.
  task automatic b_xfer(input bit we, input int adr, input logic [BY-1:0] sel, input logic [W-1:0] dat);
    bit seen;
    exp_t e;
    seen = 1'b0;
    bus_b.cyc_i = 1'b1; bus_b.stb_i = 1'b1; bus_b.we_i = we;
    bus_b.adr_i = AB'(adr); bus_b.sel_i = sel; bus_b.dat_i = dat;
    #2;
    check("b_wat_idle", bus_b.wat_o, 0);
    check("b_ce", b_ce, 1);
    check("b_we", b_we, we);
    check("b_adr", b_adr, adr);
    check("b_bes", b_bes, we ? {BY{1'b1}} : {BY{1'b0}});
    e.rd = !we; e.t = cyc_cnt;
    if (we) begin
      ref_b[adr] = merge(ref_b[adr], dat, sel, 1'b0);
      e.data = '0;
    end else begin
      e.data = ref_b[adr];
    end
    q_b.push_back(e);
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #2;
      check("b_wat_busy", bus_b.wat_o, 1);
      check("b_ce_busy", b_ce, 0);
      if (bus_b.ack_o === 1'b1) seen = 1'b1;
    end
    check("b_ack_seen", seen, 1);
    @(posedge clk); #1;
    bus_b.stb_i = 1'b0;
  endtask

  task automatic b_idle(input bit cyc);
    bus_b.cyc_i = cyc; bus_b.stb_i = 1'b0;
    if (!cyc) q_b.delete();
    #2;
    check("b_ce_idle", b_ce, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.cyc_i = 1'b1; bus_a.stb_i = 1'b1; bus_a.we_i = 1'b1;
    bus_a.adr_i = '0; bus_a.sel_i = '1; bus_a.dat_i = '0;
    bus_b.cyc_i = 1'b1; bus_b.stb_i = 1'b1; bus_b.we_i = 1'b1;
    bus_b.adr_i = '0; bus_b.sel_i = '1; bus_b.dat_i = '0;

    // Reset: no SRAM enable even with a strobe present, no ack, no stall.
    repeat (3) @(posedge clk);
    #3;
    check("rst_a_ce", a_ce, 0);
    check("rst_a_ack", bus_a.ack_o, 0);
    check("rst_a_wat", bus_a.wat_o, 0);
    check("rst_b_ce", b_ce, 0);
    check("rst_b_ack", bus_b.ack_o, 0);
    check("rst_b_wat", bus_b.wat_o, 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.cyc_i = 1'b0; bus_a.stb_i = 1'b0;
    bus_b.cyc_i = 1'b0; bus_b.stb_i = 1'b0;
    mon_en = 1'b1;

    // ---------------- DUT A (pipelined, TICKS=1, byte enables) ----------------
    // Preload word k = k*0x01010101 with back-to-back writes.
    for (int k = 0; k < 16; k++) a_cycle(1, 1, 1, k, 4'hF, 32'h01010101 * k, 0);
    a_cycle(1, 0, 0, 0, '0, '0, 0);
    a_cycle(1, 1, 1, 5, 4'hF, 32'hDEADBEEF, 0);
    a_cycle(1, 0, 0, 0, '0, '0, 0);
    a_cycle(1, 1, 1, 5, 4'b0100, 32'h00AA0000, 0);
    a_cycle(1, 1, 0, 5, 4'hF, '0, 0);
    a_cycle(1, 0, 0, 0, '0, '0, 0);
    // Burst of 8 reads, one per cycle.
    for (int k = 0; k < 8; k++) a_cycle(1, 1, 0, k, 4'hF, '0, 0);
    a_cycle(1, 0, 0, 0, '0, '0, 0);
    a_cycle(1, 0, 0, 0, '0, '0, 0);
    // Randomised traffic with gaps and occasional cycle drops.
    repeat (200) begin
      a_cycle($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)), 4'($urandom), $urandom, 0);
    end
    a_cycle(1, 0, 0, 0, '0, '0, 0);
    a_cycle(1, 0, 0, 0, '0, '0, 0);
    // Reset in the middle of a read burst.
    a_cycle(1, 1, 0, 0, 4'hF, '0, 0);
    a_cycle(1, 1, 0, 1, 4'hF, '0, 0);
    rst_a = 1'b1;
    a_cycle(1, 1, 0, 2, 4'hF, '0, 0);
    rst_a = 1'b0;
    a_cycle(1, 0, 0, 0, '0, '0, 1);
    a_cycle(1, 0, 0, 0, '0, '0, 1);
    // Cycle dropped with one ack pending, then raised again.
    a_cycle(1, 1, 0, 5, 4'hF, '0, 0);
    a_cycle(0, 0, 0, 0, '0, '0, 1);
    a_cycle(1, 0, 0, 0, '0, '0, 1);
    a_cycle(1, 0, 0, 0, '0, '0, 1);
    a_cycle(1, 1, 0, 3, 4'hF, '0, 0);
    a_cycle(1, 0, 0, 0, '0, '0, 0);
    a_cycle(0, 0, 0, 0, '0, '0, 0);

    // ---------------- DUT B (classic, TICKS=2, all lanes) ----------------
    for (int k = 0; k < 16; k++) b_xfer(1, k, 4'hF, $urandom);
    b_xfer(1, 5, 4'hF, 32'hDEADBEEF);
    b_xfer(1, 5, 4'b0100, 32'h00AA0000);
    b_xfer(0, 5, 4'hF, '0);
    b_idle(1);
    b_idle(1);
    repeat (40) begin
      b_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) b_idle(1);
    end
    b_idle(1);
    // Reset while a read is outstanding: its ack must never appear.
    bus_b.cyc_i = 1'b1; bus_b.stb_i = 1'b1; bus_b.we_i = 1'b0; bus_b.adr_i = AB'(5);
    #2;
    check("b_rst_ce", b_ce, 1);
    e.rd = 1'b1; e.data = ref_b[5]; e.t = cyc_cnt;
    q_b.push_back(e);
    @(posedge clk); #1;
    rst_b = 1'b1; bus_b.stb_i = 1'b0;
    #2;
    check("b_rst_ack_early", bus_b.ack_o, 0);
    @(posedge clk);
    q_b.delete();
    #1;
    rst_b = 1'b0;
    #2;
    check("b_rst_discard", bus_b.ack_o, 0);
    check("b_rst_wat", bus_b.wat_o, 0);
    @(posedge clk); #1;
    b_idle(1);
    b_xfer(0, 7, 4'hF, '0);
    b_idle(1);
    b_idle(1);
    b_idle(1);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
